// File: rtl/router_pkg.sv
// Shared router definitions: injector FSM states and default flit/starvation parameters.
package router_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HOLD    = 2'd1,
    STARVED = 2'd2
  } inj_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency 1 (registered count); no backpressure, holds at MAX until cleared.
module sat_counter #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; dout is combinational and driven only while a pop is accepted, else 0.
// Pushes are dropped when full and pops ignored when empty; flags are registered-state decodes.
module sync_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_wr_en & ~o_full;
  assign w_pop   = i_rd_en & ~o_empty;
  assign o_dout  = w_pop ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Pops flits from an upstream FIFO into a one-entry hold register and offers them to the router.
// Latency 1 from pop to offer; a blocked flit is held in place and flags starve after STARVE_LIMIT cycles.
module flit_injector
  import router_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  inj_en,
  input  logic                  slot_free,
  output logic                  inj_valid,
  output logic [DATA_WIDTH-1:0] inj_flit,
  output logic                  starve,
  output logic [15:0]           inj_count
);

  localparam int           CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

  inj_state_t            r_state;
  inj_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] w_hold_nxt;
  logic                  r_starve;
  logic [15:0]           r_inj_count;
  logic [CW-1:0]         w_blk_cnt;
  logic                  w_holding;
  logic                  w_inject;
  logic                  w_blocked;
  logic                  w_rd_en;
  logic                  w_hits_limit;

  assign w_holding    = (r_state != EMPTY);
  assign w_inject     = w_holding & slot_free;
  assign w_blocked    = w_holding & ~slot_free;
  // Gated by reset so a non-empty FIFO is never popped while the injector is held in reset.
  assign w_rd_en      = n_rst & ~fifo_empty & inj_en & (~w_holding | slot_free);
  assign w_hits_limit = (w_blk_cnt >= LIM_M1);

  sat_counter #(
    .MAX (STARVE_LIMIT)
  ) u_blk_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (~w_blocked),
    .i_inc (w_blocked),
    .o_cnt (w_blk_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      EMPTY: begin
        if (w_rd_en) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = fifo_dout;
        end
      end
      HOLD, STARVED: begin
        if (slot_free) begin
          if (w_rd_en) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = fifo_dout;
          end else begin
            w_state_nxt = EMPTY;
            w_hold_nxt  = '0;
          end
        end else if (w_hits_limit) begin
          w_state_nxt = STARVED;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= EMPTY;
      r_hold      <= '0;
      r_starve    <= 1'b0;
      r_inj_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_starve <= (w_state_nxt == STARVED);
      if (w_inject) begin
        r_inj_count <= r_inj_count + 16'd1;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign inj_valid  = w_holding;
  assign inj_flit   = w_holding ? r_hold : '0;
  assign starve     = r_starve;
  assign inj_count  = r_inj_count;

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, flit width; must match the upstream sync_fifo DATA_WIDTH.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive blocked cycles before starve asserts; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  DATA_WIDTH  upstream FIFO data; valid only in a cycle where fifo_rd_en=1, else 0.
REQ-007 SHALL have port fifo_rd_en  output  1  pop request to the upstream FIFO; combinational.
REQ-008 SHALL have port inj_en  input  1  injection enable; low blocks new FIFO reads only.
REQ-009 SHALL have port slot_free  input  1  router pipeline has a free input slot this cycle.
REQ-010 SHALL have port inj_valid  output  1  inj_flit holds a flit offered to the router.
REQ-011 SHALL have port inj_flit  output  DATA_WIDTH  offered flit; 0 when inj_valid=0.
REQ-012 SHALL have port starve  output  1  held flit blocked for at least STARVE_LIMIT cycles.
REQ-013 SHALL have port inj_count  output  16  flits injected since reset; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement FSM states EMPTY, HOLD, STARVED; inj_valid=1 in HOLD and STARVED.
REQ-015 Injection SHALL occur in any cycle with inj_valid=1 and slot_free=1; inj_count increments by 1 on that edge.
REQ-016 fifo_rd_en SHALL equal ~fifo_empty & inj_en & (state==EMPTY | slot_free); never asserted when fifo_empty=1.
REQ-017 On a cycle with fifo_rd_en=1 the hold register SHALL capture fifo_dout at the edge; flit appears on inj_flit the next cycle (latency 1).
REQ-018 EMPTY->HOLD on fifo_rd_en=1; otherwise stay EMPTY.
REQ-019 HOLD/STARVED with injection and fifo_rd_en=1 SHALL go to HOLD with the new flit (back-to-back, 1 flit/cycle, no bubble).
REQ-020 HOLD/STARVED with injection and fifo_rd_en=0 SHALL go to EMPTY; hold register cleared to 0.
REQ-021 HOLD/STARVED with slot_free=0 SHALL keep the flit unchanged; blocked counter increments, saturating at STARVE_LIMIT.
REQ-022 HOLD->STARVED when the blocked counter reaches STARVE_LIMIT; starve is a registered output, high exactly in STARVED.
REQ-023 Blocked counter SHALL clear to 0 on every injection and in EMPTY.
REQ-024 inj_en=0 SHALL not drop or stall injection of an already-held flit.
REQ-025 No flit SHALL be lost or duplicated; order SHALL match FIFO order.

Reset
REQ-026 n_rst=0 SHALL immediately force state=EMPTY, hold register=0, blocked counter=0, inj_count=0, starve=0, inj_valid=0, inj_flit=0.
REQ-027 Reset mid-operation SHALL discard the held flit; fifo_rd_en SHALL be 0 while n_rst=0.

Structure
REQ-028 FSM state enum, default DATA_WIDTH, and STARVE_LIMIT default SHALL live in the shared router package.
REQ-029 Blocked counter SHALL be one sub-module, sat_counter (saturating, width clog2(STARVE_LIMIT+1), sync clear).

Verification (DATA_WIDTH=8, STARVE_LIMIT=4, driven from a real sync_fifo)
REQ-030 Reset then push 0x11,0x22,0x33 with slot_free=1 -> inj_flit 0x11,0x22,0x33 on consecutive cycles, first one cycle after first fifo_rd_en, inj_count=3, inj_valid then 0.
REQ-031 Hold 0xA5 with slot_free=0 for 6 cycles -> fifo_rd_en=0, inj_flit stays 0xA5, starve rises after 4th blocked cycle, drops the cycle after slot_free=1 injects.
REQ-032 FIFO non-empty, inj_en=0 while holding 0x5A, slot_free=1 -> 0x5A injected, no fifo_rd_en, state EMPTY.
REQ-033 Assert n_rst low while holding 0x7E in STARVED -> all outputs 0 immediately, 0x7E never injected after release.
REQ-034 Preload inj_count to 0xFFFF via 65535 injections, inject one more -> inj_count=0x0000.
REQ-035 Random slot_free/inj_en/push for 10k cycles -> scoreboard: injected sequence equals pushed sequence, no fifo_rd_en while fifo_empty.
